multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ready in any memory state (range 1..15).
REQ-002 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 op  input  6  opcode field of the instruction register, sampled in DECODE.
REQ-005 mem_ready  input  1  memory completion strobe for the current access.
REQ-006 mem_req  output  1  memory access request.
REQ-007 memwrite, irwrite, pcwrite, branch, iord, regdst, memtoreg, regwrite, alusrca  output  1 each  standard multicycle datapath enables and selects.
REQ-008 alusrcb  output  2  ALU B select: 00 reg, 01 const 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
REQ-009 pcsrc  output  2  PC select: 00 ALU result, 01 ALU output register, 10 jump target.
REQ-010 aluop  output  2  to the ALU decoder: 00 add, 01 sub, 10 use funct.
REQ-011 bus_err  output  1  one-cycle pulse on memory timeout.
REQ-012 illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-013 The FSM shall have 12 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-014 DECODE shall branch on op: 100011/101011 to MEMADR, 000000 to RTYPEEX, 000100 to BEQEX, 001000 to ADDIEX, 000010 to JEX; any other value pulses illegal and goes to FETCH.
REQ-015 MEMADR shall go to MEMRD for lw and to MEMWR for sw. MEMRD goes to MEMWB. RTYPEEX goes to RTYPEWB. ADDIEX goes to ADDIWB. MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX go to FETCH.
REQ-016 FETCH, MEMRD and MEMWR are wait states: mem_req=1, and the FSM holds until mem_ready=1 on a rising edge.
REQ-017 FETCH outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready (Mealy), so the PC and IR update only on the completing cycle.
REQ-018 DECODE outputs: alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
REQ-019 MEMADR and ADDIEX outputs: alusrca=1, alusrcb=10, aluop=00.
REQ-020 MEMRD outputs: iord=1. MEMWR outputs: iord=1, memwrite=mem_ready (Mealy).
REQ-021 Writeback outputs:
- MEMWB: regwrite=1, memtoreg=1, regdst=0.
- RTYPEWB: regwrite=1, regdst=1.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0.
REQ-022 RTYPEEX outputs: alusrca=1, alusrcb=00, aluop=10.
REQ-023 BEQEX outputs: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01. JEX outputs: pcwrite=1, pcsrc=10.
REQ-024 Every output not listed for a state shall be 0 in that state.
REQ-025 Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
REQ-026 Timeout counter (4-bit):
- clears on entry to any wait state;
- increments on each cycle in a wait state while mem_ready=0.
REQ-027 When the counter equals TIMEOUT with mem_ready=0, the block shall pulse bus_err, leave PC/IR/memory unwritten, and go to FETCH.
REQ-028 mem_ready=1 in the same cycle as the timeout condition shall complete normally, with no bus_err.
REQ-029 mem_ready outside wait states shall be ignored.

Reset
REQ-030 While rst_n=0: state=FETCH, counter=0, and every output except mem_req shall be 0.
REQ-031 mem_req follows FETCH decoding (1) after reset.
REQ-032 Reset asserted mid-instruction shall abort with no further writes. The first post-reset fetch shall start on the first rising edge after rst_n deasserts.

Structure
REQ-033 The state encoding, opcode constants and the aluop/alusrcb/pcsrc encodings shall live in the shared package mips_defs.
REQ-034 The timeout counter shall be the sub-module mem_wait_timer (inputs clr, en; output expired).
REQ-035 The next-state and output logic shall be in multicycle_ctrl.

Verification
REQ-036 lw (op 100011), mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-037 sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 only in the 4th MEMWR cycle; total 7 cycles.
REQ-038 beq (000100) -> aluop=01, branch=1, pcsrc=01 in cycle 3; next cycle is FETCH.
REQ-039 op 111111 -> illegal pulses 1 cycle in DECODE; FSM returns to FETCH; no regwrite/memwrite.
REQ-040 TIMEOUT=3, mem_ready held 0 in FETCH -> bus_err pulse after 3 wait cycles with pcwrite=irwrite=0 throughout. Repeat with mem_ready=1 on the timeout cycle -> no bus_err, normal fetch.
REQ-041 rst_n pulled low during RTYPEEX -> all outputs 0 immediately; after release, FETCH with mem_req=1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcodes, datapath select encodings and the control-word struct.
package mips_defs;

  // FSM state encoding
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  // Opcodes
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU decoder request
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One cycle's worth of controller outputs
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       bus_err;
    logic       illegal;
  } ctrl_t;

  // States that issue a memory request and stall on mem_ready
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       bus_err;
  logic       illegal;

  // Controller side
  modport master (
    input  op, mem_ready,
    output mem_req, memwrite, irwrite, pcwrite, branch, iord, regdst,
           memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop, bus_err, illegal
  );

  // Datapath / memory side
  modport slave (
    output op, mem_ready,
    input  mem_req, memwrite, irwrite, pcwrite, branch, iord, regdst,
           memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop, bus_err, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Counts stalled cycles in a memory wait state; expired flags the limit.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [3:0] count;

  // Wait-cycle counter: cleared on wait-state entry, advanced while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (en) begin
      count <= count + 4'd1;
    end else begin
      count <= count;
    end
  end

  assign expired = (count == 4'(TIMEOUT));
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-wait timeout and illegal-op detect.
module multicycle_ctrl
  import mips_defs::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);
  logic [3:0] state;
  logic [3:0] next_state;
  logic       is_store;
  logic       in_wait;
  logic       expired;
  logic       timeout;
  logic       leaving;
  logic       timer_clr;
  logic       timer_en;
  ctrl_t      ctl;
  ctrl_t      ctl_out;

  assign in_wait   = is_wait_state(state);
  assign timeout   = in_wait && !bus.mem_ready && expired;
  // mem_ready wins over an expiring counter in the same cycle
  assign leaving   = !in_wait || bus.mem_ready || expired;
  assign timer_clr = leaving && is_wait_state(next_state);
  assign timer_en  = in_wait && !bus.mem_ready && !timer_clr;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Remember lw vs sw at decode so MEMADR does not depend on op later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store <= 1'b0;
    end else if (state == S_DECODE) begin
      is_store <= (bus.op == OP_SW);
    end else begin
      is_store <= is_store;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready) begin
          next_state = S_MEMWB;
        end else if (expired) begin
          next_state = S_FETCH;
        end else begin
          next_state = S_MEMRD;
        end
      end
      S_MEMWR:   next_state = (bus.mem_ready || expired) ? S_FETCH : S_MEMWR;
      S_RTYPEEX: next_state = S_RTYPEWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      default:   next_state = S_FETCH;
    endcase
  end

  // Per-state control word (Mealy terms use mem_ready)
  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_req = 1'b1;
        ctl.alusrcb = SRCB_FOUR;
        ctl.aluop   = ALUOP_ADD;
        ctl.pcsrc   = PCSRC_ALU;
        ctl.irwrite = bus.mem_ready;
        ctl.pcwrite = bus.mem_ready;
      end
      S_DECODE: begin
        ctl.alusrcb = SRCB_IMM_SL2;
        ctl.aluop   = ALUOP_ADD;
        ctl.illegal = !((bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_RTYPE) ||
                        (bus.op == OP_BEQ) || (bus.op == OP_ADDI) || (bus.op == OP_J));
      end
      S_MEMADR, S_ADDIEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_req  = 1'b1;
        ctl.iord     = 1'b1;
        ctl.memwrite = bus.mem_ready;
      end
      S_MEMWB: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
      end
      S_RTYPEEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_REG;
        ctl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctl.regwrite = 1'b1;
        ctl.regdst   = 1'b1;
      end
      S_ADDIWB:  ctl.regwrite = 1'b1;
      S_BEQEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_REG;
        ctl.aluop   = ALUOP_SUB;
        ctl.branch  = 1'b1;
        ctl.pcsrc   = PCSRC_ALUOUT;
      end
      S_JEX: begin
        ctl.pcwrite = 1'b1;
        ctl.pcsrc   = PCSRC_JUMP;
      end
      default: ctl = '0;
    endcase
    ctl.bus_err = timeout;
  end

  // Hold every enable low while reset is asserted; mem_req keeps its FETCH value
  always_comb begin
    ctl_out = '0;
    if (rst_n) begin
      ctl_out = ctl;
    end else begin
      ctl_out.mem_req = ctl.mem_req;
    end
  end

  assign bus.mem_req  = ctl_out.mem_req;
  assign bus.memwrite = ctl_out.memwrite;
  assign bus.irwrite  = ctl_out.irwrite;
  assign bus.pcwrite  = ctl_out.pcwrite;
  assign bus.branch   = ctl_out.branch;
  assign bus.iord     = ctl_out.iord;
  assign bus.regdst   = ctl_out.regdst;
  assign bus.memtoreg = ctl_out.memtoreg;
  assign bus.regwrite = ctl_out.regwrite;
  assign bus.alusrca  = ctl_out.alusrca;
  assign bus.alusrcb  = ctl_out.alusrcb;
  assign bus.pcsrc    = ctl_out.pcsrc;
  assign bus.aluop    = ctl_out.aluop;
  assign bus.bus_err  = ctl_out.bus_err;
  assign bus.illegal  = ctl_out.illegal;
endmodule
